// File: rtl/bus_rx_responder.sv
// Bus receive responder: parses framed transfers, buffers frames for MY_ID, acks/naks one cycle after the last byte.
// Output stream never stalls the bus; bus-side flow control is by admission check (nak) at header time.
module bus_rx_responder #(
  parameter logic [1:0] MY_ID   = 2'b10,
  parameter int         DEPTH   = 16,
  parameter int         TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_data,
  input  logic       bus_valid,
  output logic       ack,
  output logic       nak,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_src,
  output logic       out_last,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] src;
    logic [3:0] len;
  } hdr_t;

  typedef struct packed {
    logic [1:0] src;
    logic       last;
    logic [7:0] data;
  } entry_t;

  logic [1:0]    state;
  logic [1:0]    frm_src;
  logic [3:0]    rem;
  logic          refuse;
  logic          resp_ack;
  logic [7:0]    idle_cnt;
  logic [PW-1:0] wr_spec;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd;
  entry_t        mem [DEPTH];

  hdr_t          hdr_in;
  logic [PW-1:0] used;
  logic [PW-1:0] free;
  logic          for_me;
  logic          admit_ok;
  logic          timed_out;
  logic          rd_fire;
  entry_t        wr_ent;
  entry_t        rd_ent;

  assign hdr_in    = hdr_t'(bus_data);
  assign used      = wr_spec - rd;
  assign free      = PW'(DEPTH) - used;
  assign for_me    = (hdr_in.dest == MY_ID);
  assign admit_ok  = (free >= PW'(hdr_in.len));
  assign timed_out = !bus_valid && (idle_cnt == 8'(TIMEOUT - 1));
  assign rd_fire   = out_valid && out_ready;

  assign wr_ent.src  = frm_src;
  assign wr_ent.last = (rem == 4'd1);
  assign wr_ent.data = bus_data;

  // Control FSM and pointers; wr_spec only becomes visible to the reader once copied to wr_commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      frm_src   <= '0;
      rem       <= '0;
      refuse    <= 1'b0;
      resp_ack  <= 1'b0;
      idle_cnt  <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
      rd        <= '0;
    end else begin
      if (rd_fire) begin
        rd <= rd + 1'b1;
      end
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          if (bus_valid) begin
            frm_src <= hdr_in.src;
            rem     <= hdr_in.len;
            refuse  <= 1'b0;
            if (hdr_in.len == 4'd0) begin
              if (for_me) begin
                state    <= S_RESP;
                resp_ack <= 1'b1;
              end
            end else if (!for_me) begin
              state <= S_SKIP;
            end else if (!admit_ok) begin
              state  <= S_SKIP;
              refuse <= 1'b1;
            end else begin
              state <= S_RECV;
            end
          end
        end

        S_RECV: begin
          if (bus_valid) begin
            idle_cnt <= '0;
            wr_spec  <= wr_spec + 1'b1;
            rem      <= rem - 1'b1;
            if (rem == 4'd1) begin
              state    <= S_RESP;
              resp_ack <= 1'b1;
            end
          end else if (timed_out) begin
            // Abandon the partial frame so it never reaches the reader.
            wr_spec  <= wr_commit;
            state    <= S_RESP;
            resp_ack <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_SKIP: begin
          if (bus_valid) begin
            idle_cnt <= '0;
            rem      <= rem - 1'b1;
            if (rem == 4'd1) begin
              state    <= refuse ? S_RESP : S_IDLE;
              resp_ack <= 1'b0;
            end
          end else if (timed_out) begin
            state    <= refuse ? S_RESP : S_IDLE;
            resp_ack <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        default: begin
          if (resp_ack) begin
            wr_commit <= wr_spec;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is not reset; entries are only observable between rd and wr_commit.
  always_ff @(posedge clk) begin
    if (state == S_RECV && bus_valid) begin
      mem[wr_spec[AW-1:0]] <= wr_ent;
    end
  end

  assign rd_ent    = mem[rd[AW-1:0]];
  assign out_valid = (wr_commit != rd);
  assign out_data  = out_valid ? rd_ent.data : 8'd0;
  assign out_src   = out_valid ? rd_ent.src  : 2'd0;
  assign out_last  = out_valid ? rd_ent.last : 1'b0;

  assign ack  = (state == S_RESP) &&  resp_ack;
  assign nak  = (state == S_RESP) && !resp_ack;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_bus_rx_responder.sv
// Directed bench for bus_rx_responder: framed transfers, skip, refusal, timeout, zero-length, reset mid-frame.
module tb_bus_rx_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_data;
  logic       bus_valid;
  logic       ack;
  logic       nak;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       out_last;
  logic       busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bus_rx_responder #(.MY_ID(2'b10), .DEPTH(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .ack       (ack),
    .nak       (nak),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one bus cycle, clock it in, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    bus_valid = v;
    bus_data  = d;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    bus_data  = 8'h00;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic [1:0] s, input logic l);
    check({tag, ".valid"}, 16'(out_valid), 16'h1);
    check({tag, ".data"},  16'(out_data),  16'(d));
    check({tag, ".src"},   16'(out_src),   16'(s));
    check({tag, ".last"},  16'(out_last),  16'(l));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus_valid = 1'b0;
    bus_data  = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ack",       16'(ack),       16'h0);
    check("rst.nak",       16'(nak),       16'h0);
    check("rst.out_valid", 16'(out_valid), 16'h0);
    check("rst.busy",      16'(busy),      16'h0);
    check("rst.out_data",  16'(out_data),  16'h0);
    rst = 1'b0;
    cyc(1'b0, 8'h00);

    // 1: addressed frame of 3 bytes
    cyc(1'b1, 8'h83);
    check("t1.busy_hdr", 16'(busy), 16'h1);
    cyc(1'b1, 8'hA1);
    cyc(1'b1, 8'hB2);
    check("t1.ack_early", 16'(ack), 16'h0);
    cyc(1'b1, 8'hC3);
    check("t1.ack",        16'(ack),       16'h1);
    check("t1.nak",        16'(nak),       16'h0);
    check("t1.not_yet",    16'(out_valid), 16'h0);
    cyc(1'b0, 8'h00);
    check("t1.ack_pulse",  16'(ack),       16'h0);
    check("t1.busy_done",  16'(busy),      16'h0);
    pop_check("t1.b0", 8'hA1, 2'd0, 1'b0);
    pop_check("t1.b1", 8'hB2, 2'd0, 1'b0);
    pop_check("t1.b2", 8'hC3, 2'd0, 1'b1);
    check("t1.empty", 16'(out_valid), 16'h0);

    // 2: frame for another responder is skipped silently
    cyc(1'b1, 8'h43);
    check("t2.busy", 16'(busy), 16'h1);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    check("t2.busy_mid", 16'(busy), 16'h1);
    cyc(1'b1, 8'h03);
    check("t2.busy_end", 16'(busy),      16'h0);
    check("t2.acknak",   16'({ack, nak}), 16'h0);
    check("t2.empty",    16'(out_valid), 16'h0);

    // 3: fill all 16 entries, then a refused frame
    cyc(1'b1, 8'h88);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i));
    check("t3.ack1", 16'(ack), 16'h1);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h98);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h20 + 8'(i));
    check("t3.ack2", 16'(ack), 16'h1);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h81);
    check("t3.skip_busy", 16'(busy), 16'h1);
    cyc(1'b1, 8'hEE);
    check("t3.nak",  16'(nak), 16'h1);
    check("t3.ack0", 16'(ack), 16'h0);
    cyc(1'b0, 8'h00);
    check("t3.nak_pulse", 16'(nak), 16'h0);
    for (int i = 0; i < 16; i++) begin
      pop_check($sformatf("t3.e%0d", i),
                (i < 8) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 8),
                (i < 8) ? 2'd0 : 2'd1,
                (i == 7) || (i == 15));
    end
    check("t3.empty", 16'(out_valid), 16'h0);

    // 4: partial frame times out and is rolled back
    cyc(1'b1, 8'h94);
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    repeat (14) cyc(1'b0, 8'h00);
    check("t4.nak_early", 16'(nak),  16'h0);
    check("t4.busy_wait", 16'(busy), 16'h1);
    cyc(1'b0, 8'h00);
    check("t4.nak",       16'(nak),       16'h1);
    check("t4.no_out",    16'(out_valid), 16'h0);
    cyc(1'b0, 8'h00);
    check("t4.no_out2",   16'(out_valid), 16'h0);
    check("t4.idle",      16'(busy),      16'h0);
    cyc(1'b1, 8'h82);
    cyc(1'b1, 8'h5A);
    cyc(1'b1, 8'h6B);
    check("t4.ack", 16'(ack), 16'h1);
    cyc(1'b0, 8'h00);
    pop_check("t4.b0", 8'h5A, 2'd0, 1'b0);
    pop_check("t4.b1", 8'h6B, 2'd0, 1'b1);
    check("t4.empty", 16'(out_valid), 16'h0);

    // 5: zero-length addressed frame
    cyc(1'b1, 8'hB0);
    check("t5.ack", 16'(ack), 16'h1);
    check("t5.nak", 16'(nak), 16'h0);
    cyc(1'b0, 8'h00);
    check("t5.ack_pulse", 16'(ack),       16'h0);
    check("t5.empty",     16'(out_valid), 16'h0);
    check("t5.idle",      16'(busy),      16'h0);

    // 6: reset mid-frame with committed data pending
    cyc(1'b1, 8'h81);
    cyc(1'b1, 8'h77);
    check("t6.ack_pre", 16'(ack), 16'h1);
    cyc(1'b0, 8'h00);
    check("t6.pending", 16'(out_valid), 16'h1);
    cyc(1'b1, 8'h85);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    check("t6.busy", 16'(busy), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t6.rst_valid", 16'(out_valid),   16'h0);
    check("t6.rst_data",  16'(out_data),    16'h0);
    check("t6.rst_busy",  16'(busy),        16'h0);
    check("t6.rst_ak",    16'({ack, nak}),  16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 8'h00);
    check("t6.post_ak",   16'({ack, nak}),  16'h0);
    check("t6.post_out",  16'(out_valid),   16'h0);
    cyc(1'b1, 8'h81);
    cyc(1'b1, 8'h3C);
    check("t6.ack", 16'(ack), 16'h1);
    cyc(1'b0, 8'h00);
    pop_check("t6.b0", 8'h3C, 2'd0, 1'b1);
    check("t6.empty", 16'(out_valid), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
